// File: rtl/key_expand_inv_pkg.sv
// Shared constants for the inverse SM4 key schedule: word sizes, FK words,
// FSM state encodings and the combinational CK word generator.
package key_expand_inv_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int IDX_WIDTH  = 5;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EMIT = 3'd1;
  localparam logic [2:0] ST_CALC = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Byte j of CK_i is ((4i+j)*7) mod 256, byte 0 in the most significant lane.
  function automatic logic [31:0] ck_word(input logic [IDX_WIDTH-1:0] i);
    logic [7:0]  n;
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      n = {1'b0, i, 2'b00} + 8'(j);
      w[31-8*j -: 8] = n * 8'd7;
    end
    return w;
  endfunction

endpackage

// File: rtl/t_transform_key.sv
// Key-schedule transform T'(x) = L'(tau(x)), L'(B) = B ^ (B<<<13) ^ (B<<<23).
// Two registered stages: S-box lookup, then the linear mix.
module t_transform_key (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_din,
  output logic [31:0] o_dout
);

  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  // Row = high nibble; column c sits at bits [8*(15-c) +: 8].
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [127:0] row;
    row = SBOX_ROWS[x[7:4]];
    return row[{~x[3:0], 3'b000} +: 8];
  endfunction

  logic [31:0] w_tau;
  logic [31:0] w_lin;
  logic [31:0] r_tau;
  logic [31:0] r_dout;

  always_comb begin
    w_tau = '0;
    for (int k = 0; k < 4; k++) begin
      w_tau[8*k +: 8] = sbox(i_din[8*k +: 8]);
    end
  end

  assign w_lin = r_tau ^ {r_tau[18:0], r_tau[31:19]} ^ {r_tau[8:0], r_tau[31:9]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tau  <= '0;
      r_dout <= '0;
    end else begin
      r_tau  <= w_tau;
      r_dout <= w_lin;
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/key_expand_inv.sv
// Inverse SM4 key schedule: loads {rk28..rk31} and streams rk31 down to rk0.
// Build option KEY_INV_MK_RECOVER_EN also walks back to K0..K3 and reports the master key.
module key_expand_inv #(
  parameter int WORD_WIDTH = 32,
  parameter int IDX_WIDTH  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [4*WORD_WIDTH-1:0] i_rk_last,
  output logic                    o_busy,
  output logic                    o_rk_valid,
  input  logic                    i_rk_ready,
  output logic [WORD_WIDTH-1:0]   o_rk_out,
  output logic [IDX_WIDTH-1:0]    o_rk_idx,
  output logic                    o_done,
`ifdef KEY_INV_MK_RECOVER_EN
  output logic [4*WORD_WIDTH-1:0] o_mk_out,
  output logic                    o_mk_valid,
`endif
  output logic [2:0]              o_state
);
  import key_expand_inv_pkg::*;

  // Stream handshake: a key transfers on a cycle with o_rk_valid && i_rk_ready;
  // while valid is high and ready low, o_rk_out/o_rk_idx are held unchanged.

  logic [2:0]            r_state;
  logic [WORD_WIDTH-1:0] r_w0, r_w1, r_w2, r_w3;
  logic [IDX_WIDTH-1:0]  r_cnt;
  logic [1:0]            r_stage;
  logic [WORD_WIDTH-1:0] r_psum;
  logic                  r_busy;
  logic                  r_valid;
  logic                  r_done;
  logic [WORD_WIDTH-1:0] r_rk;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [WORD_WIDTH-1:0] w_ck;
  logic [WORD_WIDTH-1:0] w_tp;
  logic [WORD_WIDTH-1:0] w_ki;
`ifdef KEY_INV_MK_RECOVER_EN
  logic [4*WORD_WIDTH-1:0] r_mk;
  logic                    r_mk_valid;
`endif

  // r_cnt is the round index i of the key under computation in CALC/HOLD.
  assign w_ck = ck_word(r_cnt);
  assign w_ki = w_tp ^ r_w3;

  t_transform_key u_tk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_din  (r_psum),
    .o_dout (w_tp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_w0    <= '0;
      r_w1    <= '0;
      r_w2    <= '0;
      r_w3    <= '0;
      r_cnt   <= '0;
      r_stage <= '0;
      r_psum  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_rk    <= '0;
      r_idx   <= '0;
`ifdef KEY_INV_MK_RECOVER_EN
      r_mk       <= '0;
      r_mk_valid <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_w0    <= i_rk_last[127:96];
            r_w1    <= i_rk_last[95:64];
            r_w2    <= i_rk_last[63:32];
            r_w3    <= i_rk_last[31:0];
            r_rk    <= i_rk_last[31:0];
            r_idx   <= 5'd31;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= 5'd31;
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (r_valid && i_rk_ready) begin
            case (r_idx)
              5'd31: begin r_rk <= r_w2; r_idx <= 5'd30; end
              5'd30: begin r_rk <= r_w1; r_idx <= 5'd29; end
              5'd29: begin r_rk <= r_w0; r_idx <= 5'd28; end
              default: begin
                r_valid <= 1'b0;
                r_cnt   <= 5'd31;
                r_stage <= 2'd0;
                r_state <= ST_CALC;
              end
            endcase
          end
        end
        ST_CALC: begin
          r_stage <= r_stage + 2'd1;
          if (r_stage == 2'd0) begin
            r_psum <= r_w0 ^ r_w1 ^ r_w2 ^ w_ck;
          end
          if (r_stage == 2'd3) begin
            r_w3 <= r_w2;
            r_w2 <= r_w1;
            r_w1 <= r_w0;
            r_w0 <= w_ki;
`ifdef KEY_INV_MK_RECOVER_EN
            // Rounds i = 3..0 only rebuild K0..K3; they are never streamed.
            if (r_cnt < 5'd4) begin
              if (r_cnt == 5'd0) begin
                r_mk       <= {w_ki, r_w0, r_w1, r_w2} ^ {FK0, FK1, FK2, FK3};
                r_mk_valid <= 1'b1;
                r_done     <= 1'b1;
                r_state    <= ST_DONE;
              end else begin
                r_cnt <= r_cnt - 5'd1;
              end
            end else
`endif
            begin
              r_rk    <= w_ki;
              r_idx   <= r_cnt - 5'd4;
              r_valid <= 1'b1;
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (r_valid && i_rk_ready) begin
            r_valid <= 1'b0;
`ifndef KEY_INV_MK_RECOVER_EN
            if (r_idx == 5'd0) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else
`endif
            begin
              r_cnt   <= r_cnt - 5'd1;
              r_stage <= 2'd0;
              r_state <= ST_CALC;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
`ifdef KEY_INV_MK_RECOVER_EN
          r_mk_valid <= 1'b0;
`endif
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_rk_valid = r_valid;
  assign o_rk_out   = r_rk;
  assign o_rk_idx   = r_idx;
  assign o_done     = r_done;
  assign o_state    = r_state;
`ifdef KEY_INV_MK_RECOVER_EN
  assign o_mk_out   = r_mk;
  assign o_mk_valid = r_mk_valid;
`endif

endmodule

// File: tb/tb_key_expand_inv.sv
// Bench for key_expand_inv: forward SM4 key-expansion model feeds an expected
// queue of {idx, key}; a negedge monitor scores every handshake and stall.
module tb_key_expand_inv;
  import key_expand_inv_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic [127:0] i_rk_last;
  logic         o_busy;
  logic         o_rk_valid;
  logic         i_rk_ready;
  logic [31:0]  o_rk_out;
  logic [4:0]   o_rk_idx;
  logic         o_done;
  logic [2:0]   o_state;
`ifdef KEY_INV_MK_RECOVER_EN
  logic [127:0] o_mk_out;
  logic         o_mk_valid;
  localparam int DONE_LAT = 17;
`else
  localparam int DONE_LAT = 1;
`endif

  localparam logic [127:0] STD_MK = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] ALT_MK = 128'h00112233445566778899AABBCCDDEEFF;

  key_expand_inv dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_rk_last  (i_rk_last),
    .o_busy     (o_busy),
    .o_rk_valid (o_rk_valid),
    .i_rk_ready (i_rk_ready),
    .o_rk_out   (o_rk_out),
    .o_rk_idx   (o_rk_idx),
    .o_done     (o_done),
`ifdef KEY_INV_MK_RECOVER_EN
    .o_mk_out   (o_mk_out),
    .o_mk_valid (o_mk_valid),
`endif
    .o_state    (o_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  logic [127:0] sb_rows [16] = '{
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  logic [31:0] m_rk [0:31];

  function automatic logic [31:0] tprime(input logic [31:0] x);
    logic [31:0] b;
    int v;
    for (int k = 0; k < 4; k++) begin
      v = int'(x[8*k +: 8]);
      b[8*k +: 8] = sb_rows[v / 16][127 - 8*(v % 16) -: 8];
    end
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  function automatic logic [31:0] ck(input int i);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[31 - 8*j -: 8] = 8'(((4*i + j) * 7) % 256);
    return w;
  endfunction

  // Forward key expansion from the master key: rk_j = K_(j+4).
  task automatic build_model(input logic [127:0] mk);
    logic [31:0] k [0:35];
    k[0] = mk[127:96] ^ 32'hA3B1BAC6;
    k[1] = mk[95:64]  ^ 32'h56AA3350;
    k[2] = mk[63:32]  ^ 32'h677D9197;
    k[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) k[i+4] = k[i] ^ tprime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck(i));
    for (int j = 0; j < 32; j++) m_rk[j] = k[j+4];
  endtask

  // ---------------- scoreboard ----------------
  logic [36:0]  exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_done = 0;
  int           done_cyc = 0;
  int           run_hs = 0;
  int           start_cyc = 0;
  int           hs_cyc [0:31];
  logic [31:0]  first_rk, last_rk, held_rk;
  logic [4:0]   first_idx, last_idx, held_idx;
  logic [127:0] mk_at_done = '0;
  bit           stall_hold = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst_n) begin
      stall_hold = 1'b0;
    end else begin
      if (stall_hold)
        check("stall_stable", 128'({o_rk_valid, o_rk_idx, o_rk_out}), 128'({1'b1, held_idx, held_rk}));
      if (o_rk_valid && i_rk_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_key", 128'({o_rk_idx, o_rk_out}), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("rk_out", 128'(o_rk_out), 128'(e[31:0]));
          check("rk_idx", 128'(o_rk_idx), 128'(e[36:32]));
        end
        if (run_hs == 0) begin first_rk = o_rk_out; first_idx = o_rk_idx; end
        last_rk = o_rk_out;
        last_idx = o_rk_idx;
        hs_cyc[o_rk_idx] = cyc;
        run_hs++;
        stall_hold = 1'b0;
      end else if (o_rk_valid) begin
        stall_hold = 1'b1;
        held_rk = o_rk_out;
        held_idx = o_rk_idx;
      end else begin
        stall_hold = 1'b0;
      end
      if (o_done) begin
        n_done++;
        done_cyc = cyc;
`ifdef KEY_INV_MK_RECOVER_EN
        mk_at_done = o_mk_out;
`endif
      end
`ifdef KEY_INV_MK_RECOVER_EN
      if (o_done || o_mk_valid) check("mk_valid_eq_done", 128'(o_mk_valid), 128'(o_done));
`endif
    end
  end

  // ---------------- drivers ----------------
  int         ready_mode = 0;
  logic [4:0] stop_idx = 5'd0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       i_rk_ready = ($urandom_range(0, 9) < 3);
      2:       i_rk_ready = !(o_rk_valid && o_rk_idx == stop_idx);
      default: i_rk_ready = 1'b1;
    endcase
  end

  task automatic arm(input logic [127:0] mk, input int mode);
    build_model(mk);
    exp_q.delete();
    for (int j = 31; j >= 0; j--) exp_q.push_back({5'(j), m_rk[j]});
    for (int j = 0; j < 32; j++) hs_cyc[j] = -1000;
    run_hs = 0;
    ready_mode = mode;
    @(posedge clk); #1;
    i_rk_last = {m_rk[28], m_rk[29], m_rk[30], m_rk[31]};
    i_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("busy_after_start", 128'(o_busy), 128'(1));
  endtask

  task automatic run_key(input logic [127:0] mk, input int mode, input bit poke_start, input bit timing);
    int d0;
    d0 = n_done;
    arm(mk, mode);
    for (int t = 0; t < 3000 && n_done == d0; t++) begin
      @(posedge clk); #1;
      i_start = poke_start && (t == 20);
      if (i_start) i_rk_last = ~i_rk_last;
    end
    i_start = 1'b0;
    check("done_seen", 128'(n_done - d0), 128'(1));
    check("done_pulse_width", 128'(o_done), 128'(0));
    check("busy_cleared", 128'(o_busy), 128'(0));
    check("handshakes", 128'(run_hs), 128'(32));
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    check("done_latency", 128'(done_cyc - hs_cyc[0]), 128'(DONE_LAT));
`ifdef KEY_INV_MK_RECOVER_EN
    check("mk_out", mk_at_done, mk);
`endif
    if (timing) begin
      check("lat_rk31", 128'(hs_cyc[31] - start_cyc), 128'(1));
      for (int j = 0; j < 28; j++)
        check($sformatf("gap_rk%0d", j), 128'(hs_cyc[j] - hs_cyc[j+1]), 128'(5));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  d0;
    bit  found;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_rk_last = '0;
    i_rk_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 128'({o_busy, o_rk_valid, o_done, o_rk_out, o_rk_idx}), 128'(0));
    check("reset_state", 128'(o_state), 128'(ST_IDLE));
    rst_n = 1'b1;

    // Standard vector, ready always high, with latency checks.
    run_key(STD_MK, 0, 1'b0, 1'b1);
    check("model_rk31", 128'(m_rk[31]), 128'(32'h9124A012));
    check("model_rk0", 128'(m_rk[0]), 128'(32'hF12186F9));
    check("first_key", 128'({first_idx, first_rk}), 128'({5'd31, 32'h9124A012}));
    check("last_key", 128'({last_idx, last_rk}), 128'({5'd0, 32'hF12186F9}));
`ifdef KEY_INV_MK_RECOVER_EN
    check("mk_literal", mk_at_done, 128'h0123456789ABCDEFFEDCBA9876543210);
`endif

    // Random backpressure on the same vector.
    run_key(STD_MK, 1, 1'b0, 1'b0);
    check("bp_first_key", 128'({first_idx, first_rk}), 128'({5'd31, 32'h9124A012}));
    check("bp_last_key", 128'({last_idx, last_rk}), 128'({5'd0, 32'hF12186F9}));

    // Start poked mid-run, then a clean restart with another key.
    run_key(STD_MK, 0, 1'b1, 1'b0);
    run_key(ALT_MK, 0, 1'b0, 1'b0);

    // Reset while rk15 is pending.
    d0 = n_done;
    stop_idx = 5'd15;
    arm(STD_MK, 2);
    found = 1'b0;
    for (int t = 0; t < 3000 && !found; t++) begin
      @(negedge clk);
      found = o_rk_valid && (o_rk_idx == 5'd15);
    end
    check("reached_idx15", 128'(found), 128'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_reset_outputs", 128'({o_busy, o_rk_valid, o_done, o_rk_out, o_rk_idx}), 128'(0));
    check("midrun_reset_state", 128'(o_state), 128'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check("no_done_on_reset", 128'(n_done - d0), 128'(0));
    check("idle_after_reset", 128'({o_busy, o_state}), 128'({1'b0, ST_IDLE}));
    exp_q.delete();
    run_key(STD_MK, 0, 1'b0, 1'b0);
    check("post_reset_last_key", 128'({last_idx, last_rk}), 128'({5'd0, 32'hF12186F9}));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
